// File: rtl/fetch_unit_if.sv
// Fetch-side buses: instruction-memory req/ack read port and the valid/ready
// instruction output towards decode.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads memory at the counter value, buffers one
// instruction for decode, and steers the counter via inc/load pulses.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  fetch_unit_if.master      bus
);

  localparam logic [1:0] SETTLE = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] DROP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              hs;

  assign hs          = valid_q && bus.instr_ready;
  assign pc_load     = redirect;
  assign pc_load_val = redirect_addr;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q && !hs;
    pc_inc     = 1'b0;

    case (state_q)
      SETTLE: begin
        // A redirect keeps us here so the loaded counter value is sampled next cycle.
        if (!redirect && (!valid_q || hs)) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
        end
      end
      REQ: begin
        if (redirect) begin
          if (bus.mem_ack) begin
            state_d   = SETTLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = DROP;
          end
        end else if (bus.mem_ack) begin
          state_d    = SETTLE;
          mem_req_d  = 1'b0;
          instr_d    = bus.mem_rdata;
          instr_pc_d = mem_addr_q;
          valid_d    = 1'b1;
          pc_inc     = 1'b1;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_d   = SETTLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = SETTLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (redirect) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a program-counter model and a
// wait-state-configurable instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_inc, pc_load;
  logic [31:0] pc_load_val;
  logic        redirect;
  logic [31:0] redirect_addr;
  int unsigned mem_wait;
  int unsigned wcnt;
  int          n_checks = 0;
  int          n_err    = 0;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_load_val  (pc_load_val),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Program counter the fetch unit steers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= '0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc)  pc <= pc + 32'd1;
  end

  // Memory acks once the request has been waiting mem_wait cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wcnt <= 0;
    else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else                                  wcnt <= 0;
  end
  assign bus.mem_ack   = bus.mem_req && (wcnt >= mem_wait);
  assign bus.mem_rdata = 32'hC000_0000 ^ bus.mem_addr;

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    bus.instr_ready = 1'b1;
    mem_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req",   bus.mem_req, 0);
    check_eq("rst_addr",  bus.mem_addr, 0);
    check_eq("rst_valid", bus.instr_valid, 0);
    check_eq("rst_instr", bus.instr, 0);
    check_eq("rst_ipc",   bus.instr_pc, 0);
    check_eq("rst_inc",   pc_inc, 0);
    check_eq("rst_load",  pc_load, 0);

    // Zero-wait streaming
    rst_n = 1'b1;
    check_eq("first_settle_req", bus.mem_req, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("zw_req",   bus.mem_req, 1);
      check_eq("zw_addr",  bus.mem_addr, k);
      check_eq("zw_inc",   pc_inc, 1);
      tick();
      check_eq("zw_req_lo", bus.mem_req, 0);
      check_eq("zw_valid",  bus.instr_valid, 1);
      check_eq("zw_ipc",    bus.instr_pc, k);
      check_eq("zw_instr",  bus.instr, exp_data(k));
      check_eq("zw_inc_lo", pc_inc, 0);
      if (k < 3) tick();
    end

    // Three wait states
    mem_wait = 3;
    tick();
    for (int j = 0; j < 4; j++) begin
      check_eq("ws_req",  bus.mem_req, 1);
      check_eq("ws_addr", bus.mem_addr, 4);
      check_eq("ws_inc",  pc_inc, (j == 3));
      tick();
    end
    check_eq("ws_valid", bus.instr_valid, 1);
    check_eq("ws_ipc",   bus.instr_pc, 4);
    check_eq("ws_req_lo", bus.mem_req, 0);

    // Backpressure for six cycles
    mem_wait = 0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("bp_req",   bus.mem_req, 0);
      check_eq("bp_valid", bus.instr_valid, 1);
      check_eq("bp_ipc",   bus.instr_pc, 4);
      check_eq("bp_instr", bus.instr, exp_data(4));
      tick();
    end
    bus.instr_ready = 1'b1;
    check_eq("bp_hs_req", bus.mem_req, 0);
    tick();
    check_eq("bp_next_req",   bus.mem_req, 1);
    check_eq("bp_next_addr",  bus.mem_addr, 5);
    check_eq("bp_next_valid", bus.instr_valid, 0);
    check_eq("bp_next_inc",   pc_inc, 1);
    tick();
    check_eq("bp_after_ipc", bus.instr_pc, 5);
    check_eq("bp_after_valid", bus.instr_valid, 1);

    // Redirect in REQ before ack
    mem_wait = 2;
    tick();
    check_eq("rd_addr", bus.mem_addr, 6);
    redirect = 1'b1;
    redirect_addr = 32'h40;
    #1;
    check_eq("rd_load",    pc_load, 1);
    check_eq("rd_inc",     pc_inc, 0);
    check_eq("rd_loadval", pc_load_val, 32'h40);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("drop_req",   bus.mem_req, 1);
    check_eq("drop_addr",  bus.mem_addr, 6);
    check_eq("drop_valid", bus.instr_valid, 0);
    check_eq("drop_load",  pc_load, 0);
    tick();
    check_eq("drop_ack_inc", pc_inc, 0);
    check_eq("drop_ack_req", bus.mem_req, 1);
    mem_wait = 0;
    tick();
    check_eq("drop_done_req",   bus.mem_req, 0);
    check_eq("drop_done_valid", bus.instr_valid, 0);
    tick();
    check_eq("rd_target_addr", bus.mem_addr, 32'h40);
    check_eq("rd_target_inc",  pc_inc, 1);
    tick();
    check_eq("rd_target_ipc", bus.instr_pc, 32'h40);

    // Redirect in SETTLE to 5, then redirect coincident with ack at pc=5
    redirect = 1'b1;
    redirect_addr = 32'h5;
    #1;
    check_eq("rs_load", pc_load, 1);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("rs_flush_valid", bus.instr_valid, 0);
    check_eq("rs_req",         bus.mem_req, 0);
    tick();
    check_eq("ra_addr", bus.mem_addr, 5);
    redirect = 1'b1;
    redirect_addr = 32'h80;
    #1;
    check_eq("ra_ack",  bus.mem_ack, 1);
    check_eq("ra_inc",  pc_inc, 0);
    check_eq("ra_load", pc_load, 1);
    tick();
    redirect = 1'b0;
    #1;
    check_eq("ra_req_lo", bus.mem_req, 0);
    check_eq("ra_valid",  bus.instr_valid, 0);
    tick();
    check_eq("ra_next_addr", bus.mem_addr, 32'h80);
    check_eq("ra_next_inc",  pc_inc, 1);
    tick();
    check_eq("ra_next_ipc",   bus.instr_pc, 32'h80);
    check_eq("ra_next_instr", bus.instr, exp_data(32'h80));

    // Async reset in the middle of a request
    mem_wait = 3;
    tick();
    check_eq("mr_addr", bus.mem_addr, 32'h81);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mr_req",   bus.mem_req, 0);
    check_eq("mr_maddr", bus.mem_addr, 0);
    check_eq("mr_valid", bus.instr_valid, 0);
    check_eq("mr_instr", bus.instr, 0);
    check_eq("mr_ipc",   bus.instr_pc, 0);
    check_eq("mr_inc",   pc_inc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_wait = 0;
    check_eq("mr_settle_req", bus.mem_req, 0);
    tick();
    check_eq("mr_restart_req",  bus.mem_req, 1);
    check_eq("mr_restart_addr", bus.mem_addr, 0);
    check_eq("mr_restart_inc",  pc_inc, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
